bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//   3-digit BCD down-counter (999..000) paced by a 1 s prescaled tick.
//   Complement of the up-counting BCD display chain: operator loads a start
//   value from switches, starts/pauses it with a push-button, gets a DONE flag
//   at 000. bcd_out feeds the existing BCD->7-seg decoders; done drives an LED.
// PARAMETERS
//   TICK_DIV  50000000  clk cycles per count step (use 4 in simulation)
// PORTS
//   clk         in   1   system clock, 50 MHz on board; all logic on posedge
//   aclr        in   1   asynchronous, active-low reset
//   load_n      in   1   push-button, active-low, asynchronous to clk
//   start_n     in   1   push-button, active-low, asynchronous to clk
//   load_val    in   12  BCD start value {hundreds,tens,ones}, sampled on load
//   bcd_out     out  12  current value {hundreds,tens,ones}
//   running     out  1   high while state==RUN
//   done        out  1   high while state==DONE
//   tick        out  1   1-cycle pulse on each decrement step
// BEHAVIOUR
//   Reset (aclr=0): bcd_out=000, state IDLE, running=0, done=0, tick=0,
//     prescaler=0, synchronizers preset to 1 (no false press after reset).
//   Button path, per key: 2-FF sync s1,s2 + prev reg s3; press = s3 & ~s2.
//     Action on the 3rd rising edge counting the edge that first samples key
//     low. One action per press; held key gives no repeats.
//   Load clamp: any load_val digit >9 is loaded as 9.
//   States IDLE, RUN, PAUSE, DONE:
//     load press (any state)  -> bcd_out=clamp(load_val), prescaler=0, IDLE.
//     IDLE  + start, value!=000 -> RUN, prescaler=0.
//     IDLE  + start, value==000 -> stay IDLE (ignored).
//     RUN   + start              -> PAUSE; prescaler holds its count.
//     PAUSE + start              -> RUN; prescaler resumes from held count.
//     DONE  + start              -> IDLE, value stays 000, done drops.
//     load and start press same cycle: load wins, start discarded.
//   Prescaler: counts 0..TICK_DIV-1 only in RUN, wraps to 0; tick=1 for the
//     cycle it equals TICK_DIV-1 (registered, so decrement lands on that edge).
//     First decrement exactly TICK_DIV cycles after entering RUN from IDLE.
//   Decrement: ones-1; ones 0->9 borrows into tens; tens 0->9 borrows into
//     hundreds. Example 100 -> 099, 010 -> 009.
//   Reaching 000 on a tick: same edge state -> DONE, running=0, done=1; no
//     further ticks; never wraps to 999.
//   Tick coinciding with start (pause): decrement applied, then PAUSE.
//   Tick coinciding with load: load wins, decrement discarded.
//   aclr mid-count: immediate return to reset values, no partial update.
//   bcd_out, running, done, tick all registered; no comb path input->output.
// STRUCTURE
//   timer_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2,
//     DONE=2'd3) and BCD_MAX=4'd9; shared with future timer/clock blocks.
//   Sub-module bcd_digit_down: one digit, inputs en, borrow_in, load, d;
//     outputs q[3:0], borrow_out (q==0 & borrow_in). Instantiated 3x, chained.
//   Key sync/edge-detect and prescaler inline in top.
// TESTING  (TICK_DIV=4)
//   Reset: aclr low with keys low -> all outputs 0, no action after release.
//   load_val=12'h103, load press, start press -> 102,101,100,099,...,000 at
//     4-cycle spacing; done=1 on the 000 edge; running=0; bcd_out stays 000.
//   Pause: start again after 2 steps -> value frozen for 40 cycles; resume ->
//     next tick comes after remaining prescaler cycles, not a full 4.
//   Clamp: load_val=12'hAF5 -> bcd_out=12'h995; start at 000 -> stays IDLE.
//   Collisions: load+start same cycle -> IDLE with new value; load on tick
//     cycle -> loaded value, no decrement; aclr pulse in RUN -> 000, IDLE.
//   Held key 100 cycles -> exactly one state change, at 3rd edge after press.

Source files
------------

// File: rtl/bcd_countdown_timer_pkg.sv
// bcd_countdown_timer_pkg: shared state encoding, BCD digit limit and load clamp helper
package bcd_countdown_timer_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_e;
   localparam logic [3:0] BCD_MAX = 4'd9;
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction
endpackage

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: operator keys/switches in (load_n, start_n, load_val); display and status out (bcd_out, running, done, tick)
interface bcd_countdown_timer_if;
   logic        load_n;
   logic        start_n;
   logic [11:0] load_val;
   logic [11:0] bcd_out;
   logic        running;
   logic        done;
   logic        tick;
   modport master (output load_n, start_n, load_val, input bcd_out, running, done, tick);
   modport slave  (input load_n, start_n, load_val, output bcd_out, running, done, tick);
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// bcd_digit_down: one BCD down-counting digit; ports clk, aclr, en, borrow_in, load, d[3:0] in; q[3:0], borrow_out out
module bcd_digit_down
   import bcd_countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       aclr,
   input  logic       en,
   input  logic       borrow_in,
   input  logic       load,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       borrow_out
);
   logic [3:0] q_q, q_d;
   always_comb q_d = load ? bcd_clamp(d) : (en && borrow_in) ? ((q_q == 4'd0) ? BCD_MAX : q_q - 4'd1) : q_q;
   always_ff @(posedge clk or negedge aclr)
      if (!aclr) q_q <= 4'd0;
      else       q_q <= q_d;
   assign q          = q_q;
   assign borrow_out = (q_q == 4'd0) & borrow_in;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: 3-digit BCD countdown paced by a prescaled tick; ports clk, aclr (async active-low), bus (slave: keys/load_val in, bcd_out/running/done/tick out)
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
#(
   parameter int TICK_DIV = 50000000
) (
   input  logic                   clk,
   input  logic                   aclr,
   bcd_countdown_timer_if.slave   bus
);
   localparam int             PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  P_MAX = PW'(TICK_DIV - 1);
   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic [2:0]    ld_q, st_q;
   logic          ld_p, st_p, dec, last;
   logic [3:0]    b;
   logic [11:0]   val;
   // sync stages: [0]=s1, [1]=s2, [2]=s3 (previous s2); a press is a falling s2
   assign ld_p = ld_q[2] & ~ld_q[1];
   assign st_p = st_q[2] & ~st_q[1];
   // tick_q is only ever high in RUN; b[3] (all digits zero) guards against wrap to 999
   assign dec  = tick_q & ~ld_p & ~b[3];
   assign last = dec && (val == 12'h001);
   assign b[0] = 1'b1;
   for (genvar i = 0; i < 3; i++) begin : g_dig
      bcd_digit_down u_dig (
         .clk        (clk),
         .aclr       (aclr),
         .en         (dec),
         .borrow_in  (b[i]),
         .load       (ld_p),
         .d          (bus.load_val[4*i +: 4]),
         .q          (val[4*i +: 4]),
         .borrow_out (b[i+1])
      );
   end
   always_comb begin
      state_d = ld_p  ? IDLE :
                last  ? DONE :
                !st_p ? state_q :
                (state_q == IDLE)  ? ((val != 12'h000) ? RUN : IDLE) :
                (state_q == RUN)   ? PAUSE :
                (state_q == PAUSE) ? RUN : IDLE;
      // pausing keeps the count so a resume only waits out the remainder of the step
      presc_d = (ld_p || (state_q == IDLE && state_d == RUN)) ? '0 :
                (state_q == RUN) ? ((presc_q == P_MAX) ? '0 : presc_q + 1'b1) : presc_q;
      tick_d  = (state_d == RUN) && (presc_d == P_MAX);
   end
   always_ff @(posedge clk or negedge aclr)
      if (!aclr) begin
         state_q <= IDLE;
         presc_q <= '0;
         tick_q  <= 1'b0;
         ld_q    <= 3'b111;
         st_q    <= 3'b111;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         ld_q    <= {ld_q[1:0], bus.load_n};
         st_q    <= {st_q[1:0], bus.start_n};
      end
   assign bus.bcd_out = val;
   assign bus.running = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.tick    = tick_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed stimulus, decimal behavioural model compared every cycle, plus literal checkpoints
module tb_bcd_countdown_timer;
   localparam int TD = 4;
   logic clk = 1'b0;
   logic aclr;
   int vectors = 0;
   int miscompares = 0;
   bcd_countdown_timer_if bus();
   bcd_countdown_timer #(.TICK_DIV(TD)) dut (.clk(clk), .aclr(aclr), .bus(bus));
   always #5 clk = ~clk;
   task automatic cmp12(input string name, input logic [11:0] got, input logic [11:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic cmp1(input string name, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask
   // model: value as a plain decimal number, state 0 idle / 1 run / 2 pause / 3 done,
   // ph = cycles spent in the current step while running
   int m_val = 0;
   int m_st  = 0;
   int m_ph  = 0;
   bit lh[3] = '{1'b1, 1'b1, 1'b1};
   bit sh[3] = '{1'b1, 1'b1, 1'b1};
   function automatic int dmin9(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction
   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   always @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         m_val = 0; m_st = 0; m_ph = 0;
         lh = '{1'b1, 1'b1, 1'b1};
         sh = '{1'b1, 1'b1, 1'b1};
      end else begin
         // a press acts when the key was seen high three edges back and low two edges back
         bit lp, sp, tk;
         lp = lh[2] && !lh[1];
         sp = sh[2] && !sh[1];
         lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = bus.load_n;
         sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = bus.start_n;
         tk = (m_st == 1) && (m_ph == TD - 1);
         if (lp) begin
            m_val = 100 * dmin9(bus.load_val[11:8]) + 10 * dmin9(bus.load_val[7:4]) + dmin9(bus.load_val[3:0]);
            m_st = 0; m_ph = 0;
         end else begin
            if (m_st == 1) begin
               m_ph = (m_ph + 1) % TD;
               if (tk) m_val = m_val - 1;
            end
            if (m_st == 1 && m_val == 0) m_st = 3;
            else if (sp) begin
               if (m_st == 0) begin
                  if (m_val != 0) begin m_st = 1; m_ph = 0; end
               end
               else if (m_st == 1) m_st = 2;
               else if (m_st == 2) m_st = 1;
               else m_st = 0;
            end
         end
      end
   end
   always @(negedge clk) begin
      cmp12("model_bcd_out", bus.bcd_out, to_bcd(m_val));
      cmp1("model_running", bus.running, m_st == 1);
      cmp1("model_done", bus.done, m_st == 3);
      cmp1("model_tick", bus.tick, (m_st == 1) && (m_ph == TD - 1));
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic press(input bit ld, input bit st);
      bus.load_n = !ld; bus.start_n = !st;
      @(negedge clk);
      bus.load_n = 1'b1; bus.start_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask
   initial begin
      aclr = 1'b0; bus.load_n = 1'b0; bus.start_n = 1'b0; bus.load_val = 12'h000;
      cyc(3);
      cmp12("rst_bcd", bus.bcd_out, 12'h000);
      cmp1("rst_run", bus.running, 1'b0);
      cmp1("rst_done", bus.done, 1'b0);
      cmp1("rst_tick", bus.tick, 1'b0);
      bus.load_n = 1'b1; bus.start_n = 1'b1; aclr = 1'b1;
      cyc(5);
      cmp1("post_rst_idle", bus.running, 1'b0);
      bus.load_val = 12'h103;
      press(1, 0);
      cmp12("load_103", bus.bcd_out, 12'h103);
      press(0, 1);
      cmp1("start_run", bus.running, 1'b1);
      cyc(2);
      cmp1("no_tick_yet", bus.tick, 1'b0);
      cyc(1);
      cmp1("tick_cycle", bus.tick, 1'b1);
      cmp12("before_dec", bus.bcd_out, 12'h103);
      cyc(1);
      cmp12("dec_102", bus.bcd_out, 12'h102);
      cyc(4);
      cmp12("dec_101", bus.bcd_out, 12'h101);
      press(0, 1);
      cmp1("paused", bus.running, 1'b0);
      cyc(40);
      cmp12("frozen_101", bus.bcd_out, 12'h101);
      press(0, 1);
      cmp1("resume_tick", bus.tick, 1'b1);
      cyc(1);
      cmp12("resume_100", bus.bcd_out, 12'h100);
      cyc(4);
      cmp12("borrow_099", bus.bcd_out, 12'h099);
      for (int i = 0; i < 450 && !bus.done; i++) @(negedge clk);
      cmp1("done_reached", bus.done, 1'b1);
      cmp12("done_000", bus.bcd_out, 12'h000);
      cmp1("done_not_run", bus.running, 1'b0);
      cyc(10);
      cmp12("stays_000", bus.bcd_out, 12'h000);
      cmp1("no_tick_done", bus.tick, 1'b0);
      press(0, 1);
      cmp1("done_to_idle", bus.done, 1'b0);
      press(0, 1);
      cmp1("start_at_000", bus.running, 1'b0);
      bus.load_val = 12'hAF5;
      press(1, 0);
      cmp12("clamp_995", bus.bcd_out, 12'h995);
      bus.load_val = 12'h042;
      press(1, 1);
      cmp12("both_load", bus.bcd_out, 12'h042);
      cmp1("both_idle", bus.running, 1'b0);
      press(0, 1);
      cyc(1);
      bus.load_val = 12'h777;
      press(1, 0);
      cmp12("load_on_tick", bus.bcd_out, 12'h777);
      cmp1("load_on_tick_idle", bus.running, 1'b0);
      press(0, 1);
      cyc(6);
      #2 aclr = 1'b0;
      #1;
      cmp12("aclr_bcd", bus.bcd_out, 12'h000);
      cmp1("aclr_run", bus.running, 1'b0);
      @(negedge clk);
      aclr = 1'b1;
      cyc(2);
      cmp1("aclr_idle", bus.running, 1'b0);
      bus.load_val = 12'h999;
      press(1, 0);
      bus.start_n = 1'b0;
      cyc(2);
      cmp1("held_2nd_edge", bus.running, 1'b0);
      cyc(1);
      cmp1("held_3rd_edge", bus.running, 1'b1);
      cyc(97);
      cmp1("held_no_repeat", bus.running, 1'b1);
      bus.start_n = 1'b1;
      cyc(8);
      cmp1("release_no_action", bus.running, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
